// File: rtl/int_wb_collector_if.sv
// Result-source and write-port bundle for the integer writeback collector.
// The collector is the slave: it sinks src_* results and drives write/completion ports.
interface int_wb_collector_if #(
    parameter int NUM_SRC = 4,
    parameter int NUM_WP  = 2,
    parameter int ROB_W   = 5,
    parameter int PRF_W   = 6
);
    logic [NUM_SRC-1:0]          src_vld_i;
    logic [NUM_SRC-1:0]          src_rdy_o;
    logic [NUM_SRC*32-1:0]       src_data_i;
    logic [NUM_SRC*PRF_W-1:0]    src_dest_i;
    logic [NUM_SRC-1:0]          src_wb_i;
    logic [NUM_SRC*ROB_W-1:0]    src_rob_i;

    logic [NUM_WP-1:0]           wp_wen_o;
    logic [NUM_WP*32-1:0]        wp_data_o;
    logic [NUM_WP*PRF_W-1:0]     wp_dest_o;
    logic [NUM_WP-1:0]           cmp_vld_o;
    logic [NUM_WP*ROB_W-1:0]     cmp_rob_o;

    modport master (
        output src_vld_i, src_data_i, src_dest_i, src_wb_i, src_rob_i,
        input  src_rdy_o,
        input  wp_wen_o, wp_data_o, wp_dest_o, cmp_vld_o, cmp_rob_o
    );

    modport slave (
        input  src_vld_i, src_data_i, src_dest_i, src_wb_i, src_rob_i,
        output src_rdy_o,
        output wp_wen_o, wp_data_o, wp_dest_o, cmp_vld_o, cmp_rob_o
    );
endinterface

// File: rtl/int_wb_collector.sv
// Per-source result FIFOs arbitrated round-robin onto NUM_WP write/completion ports; 2-cycle latency.
// src_rdy_o reflects registered FIFO occupancy only; a full source is held off until its head pops.
module int_wb_collector #(
    parameter int NUM_SRC = 4,
    parameter int NUM_WP  = 2,
    parameter int DEPTH   = 2,
    parameter int ROB_W   = 5,
    parameter int PRF_W   = 6
) (
    input  logic cpu_clock_i,
    input  logic cpu_reset_i,
    input  logic flush_i,
    int_wb_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [31:0]      data;
        logic [PRF_W-1:0] dest;
        logic             wb;
        logic [ROB_W-1:0] rob;
    } ent_t;

    ent_t             mem     [NUM_SRC][DEPTH];
    logic [AW-1:0]    wr_ptr  [NUM_SRC];
    logic [AW-1:0]    rd_ptr  [NUM_SRC];
    logic [CW-1:0]    count   [NUM_SRC];
    ent_t             src_ent [NUM_SRC];
    ent_t             head    [NUM_SRC];
    logic [NUM_SRC-1:0] rdy;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] grant;

    logic [RW-1:0]    rr_ptr;
    logic [RW-1:0]    last_src;
    logic [RW-1:0]    rr_next;
    logic [NUM_WP-1:0] port_vld;
    ent_t             port_ent [NUM_WP];

    logic [NUM_WP-1:0]        wen_q;
    logic [NUM_WP*32-1:0]     data_q;
    logic [NUM_WP*PRF_W-1:0]  dest_q;
    logic [NUM_WP-1:0]        cvld_q;
    logic [NUM_WP*ROB_W-1:0]  crob_q;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            rdy[s]          = (count[s] != CW'(DEPTH));
            push[s]         = bus.src_vld_i[s] & rdy[s];
            src_ent[s].data = bus.src_data_i[32*s +: 32];
            src_ent[s].dest = bus.src_dest_i[PRF_W*s +: PRF_W];
            src_ent[s].wb   = bus.src_wb_i[s];
            src_ent[s].rob  = bus.src_rob_i[ROB_W*s +: ROB_W];
            head[s]         = mem[s][rd_ptr[s]];
        end
    end

    assign bus.src_rdy_o = rdy;

    // Scan from rr_ptr; the n-th non-empty source found drives port n.
    always_comb begin
        int            n;
        logic [RW-1:0] sidx;
        n        = 0;
        sidx     = '0;
        grant    = '0;
        port_vld = '0;
        last_src = '0;
        for (int k = 0; k < NUM_WP; k++) begin
            port_ent[k] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            sidx = RW'((int'(rr_ptr) + i) % NUM_SRC);
            if (count[sidx] != '0 && n < NUM_WP) begin
                grant[sidx] = 1'b1;
                for (int k = 0; k < NUM_WP; k++) begin
                    if (k == n) begin
                        port_vld[k] = 1'b1;
                        port_ent[k] = head[sidx];
                    end
                end
                last_src = sidx;
                n++;
            end
        end
    end

    assign rr_next = (last_src == RW'(NUM_SRC - 1)) ? '0 : last_src + RW'(1);

    always_ff @(posedge cpu_clock_i) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!cpu_reset_i && !flush_i && push[s]) begin
                mem[s][wr_ptr[s]] <= src_ent[s];
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || flush_i) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
            wen_q  <= '0;
            data_q <= '0;
            dest_q <= '0;
            cvld_q <= '0;
            crob_q <= '0;
            // A flush keeps the fairness position; only reset rewinds it.
            if (cpu_reset_i) begin
                rr_ptr <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + AW'(1);
                end
                if (grant[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + AW'(1);
                end
                count[s] <= count[s] + CW'(push[s]) - CW'(grant[s]);
            end
            if (|grant) begin
                rr_ptr <= rr_next;
            end
            for (int k = 0; k < NUM_WP; k++) begin
                wen_q[k]                 <= port_vld[k] & port_ent[k].wb;
                data_q[32*k +: 32]       <= port_ent[k].data;
                dest_q[PRF_W*k +: PRF_W] <= port_ent[k].dest;
                cvld_q[k]                <= port_vld[k];
                crob_q[ROB_W*k +: ROB_W] <= port_ent[k].rob;
            end
        end
    end

    assign bus.wp_wen_o  = wen_q;
    assign bus.wp_data_o = data_q;
    assign bus.wp_dest_o = dest_q;
    assign bus.cmp_vld_o = cvld_q;
    assign bus.cmp_rob_o = crob_q;
endmodule

// File: tb/tb_int_wb_collector.sv
// Bench for int_wb_collector: per-source result queues with round-robin draining as the reference.
module tb_int_wb_collector;
    localparam int NUM_SRC = 4;
    localparam int NUM_WP  = 2;
    localparam int DEPTH   = 2;
    localparam int ROB_W   = 5;
    localparam int PRF_W   = 6;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    int_wb_collector_if #(.NUM_SRC(NUM_SRC), .NUM_WP(NUM_WP), .ROB_W(ROB_W), .PRF_W(PRF_W)) bus ();

    int_wb_collector #(
        .NUM_SRC(NUM_SRC), .NUM_WP(NUM_WP), .DEPTH(DEPTH), .ROB_W(ROB_W), .PRF_W(PRF_W)
    ) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .flush_i     (flush),
        .bus         (bus)
    );

    typedef struct {
        logic [31:0]      data;
        logic [PRF_W-1:0] dest;
        logic             wb;
        logic [ROB_W-1:0] rob;
    } res_t;

    res_t q [NUM_SRC][$];
    int   rr;
    bit   known;
    bit   acc [NUM_SRC];
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input bit v, input logic [31:0] d,
                         input logic [PRF_W-1:0] dst, input bit wb, input logic [ROB_W-1:0] rob);
        bus.src_vld_i[s]              = v;
        bus.src_data_i[32*s +: 32]    = d;
        bus.src_dest_i[PRF_W*s +: PRF_W] = dst;
        bus.src_wb_i[s]               = wb;
        bus.src_rob_i[ROB_W*s +: ROB_W]  = rob;
    endtask

    task automatic rnd(input int s);
        drive(s, 1'b1, $urandom, PRF_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              ROB_W'($urandom_range(0, 31)));
    endtask

    task automatic idle_all();
        for (int s = 0; s < NUM_SRC; s++) drive(s, 1'b0, 32'h0, '0, 1'b0, '0);
    endtask

    // One clock: predict from queue contents, advance, compare registered outputs.
    task automatic step();
        res_t e;
        int   n;
        int   last;
        int   s;
        logic [NUM_SRC-1:0]       erdy;
        logic [NUM_WP-1:0]        ewen, evld;
        logic [NUM_WP*32-1:0]     edata;
        logic [NUM_WP*PRF_W-1:0]  edest;
        logic [NUM_WP*ROB_W-1:0]  erob;
        if (known) begin
            for (int i = 0; i < NUM_SRC; i++) erdy[i] = (q[i].size() < DEPTH);
            chk("src_rdy", 64'(bus.src_rdy_o), 64'(erdy));
        end
        ewen = '0; evld = '0; edata = '0; edest = '0; erob = '0;
        for (int i = 0; i < NUM_SRC; i++) acc[i] = 1'b0;
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) q[i].delete();
            rr = 0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) q[i].delete();
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                acc[i] = (bus.src_vld_i[i] === 1'b1) && (q[i].size() < DEPTH);
            n = 0;
            last = 0;
            for (int i = 0; i < NUM_SRC; i++) begin
                s = (rr + i) % NUM_SRC;
                if (q[s].size() != 0 && n < NUM_WP) begin
                    e = q[s].pop_front();
                    evld[n] = 1'b1;
                    ewen[n] = e.wb;
                    edata[32*n +: 32] = e.data;
                    edest[PRF_W*n +: PRF_W] = e.dest;
                    erob[ROB_W*n +: ROB_W] = e.rob;
                    last = s;
                    n++;
                end
            end
            if (n > 0) rr = (last + 1) % NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc[i]) begin
                    e.data = bus.src_data_i[32*i +: 32];
                    e.dest = bus.src_dest_i[PRF_W*i +: PRF_W];
                    e.wb   = bus.src_wb_i[i];
                    e.rob  = bus.src_rob_i[ROB_W*i +: ROB_W];
                    q[i].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("wp_wen",  64'(bus.wp_wen_o),  64'(ewen));
        chk("wp_data", 64'(bus.wp_data_o), 64'(edata));
        chk("wp_dest", 64'(bus.wp_dest_o), 64'(edest));
        chk("cmp_vld", 64'(bus.cmp_vld_o), 64'(evld));
        chk("cmp_rob", 64'(bus.cmp_rob_o), 64'(erob));
        known = 1'b1;
    endtask

    // Sources in mask keep pushing; a result is replaced only once it was accepted.
    task automatic traffic(input logic [NUM_SRC-1:0] mask, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!mask[s]) drive(s, 1'b0, 32'h0, '0, 1'b0, '0);
                else if (bus.src_vld_i[s] !== 1'b1 || acc[s]) rnd(s);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rr     = 0;
        known  = 1'b0;
        rst    = 1'b1;
        flush  = 1'b0;
        idle_all();
        step();
        step();
        rst = 1'b0;

        // single result from src0
        drive(0, 1'b1, 32'hDEADBEEF, 6'd12, 1'b1, 5'd3);
        step();
        idle_all();
        step();
        chk("single_p0_data", 64'(bus.wp_data_o[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("single_p0_dest", 64'(bus.wp_dest_o[5:0]), 64'd12);
        chk("single_p1_idle", 64'(bus.wp_data_o[63:32]), 64'd0);
        step();

        // four-way contention from rr_ptr = 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) rnd(s);
        step();
        idle_all();
        step();
        step();
        drive(3, 1'b1, 32'h3333_0003, 6'd33, 1'b1, 5'd30);
        drive(0, 1'b1, 32'h0000_0A0A, 6'd10, 1'b1, 5'd1);
        step();
        idle_all();
        step();
        chk("rr_wrap_port0_rob", 64'(bus.cmp_rob_o[4:0]), 64'd1);
        step();

        // fairness with src3 idle
        traffic(4'b0111, 12);
        idle_all();
        repeat (4) step();

        // completion-only result
        drive(2, 1'b1, $urandom, 6'd5, 1'b0, 5'd17);
        step();
        idle_all();
        step();
        chk("cmponly_vld", 64'(bus.cmp_vld_o), 64'b01);
        chk("cmponly_rob", 64'(bus.cmp_rob_o[4:0]), 64'd17);
        chk("cmponly_wen", 64'(bus.wp_wen_o), 64'd0);
        step();

        // backpressure: everyone pushes
        traffic(4'b1111, 20);
        idle_all();
        repeat (6) step();

        // flush mid-traffic
        traffic(4'b1111, 5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_cmp_vld", 64'(bus.cmp_vld_o), 64'd0);
        chk("flush_rdy", 64'(bus.src_rdy_o), 64'hF);
        idle_all();
        repeat (3) step();

        // reset mid-traffic, then a lone src3 push lands on port0
        traffic(4'b1111, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_rdy", 64'(bus.src_rdy_o), 64'hF);
        idle_all();
        drive(3, 1'b1, 32'hCAFE_F00D, 6'd40, 1'b1, 5'd9);
        step();
        idle_all();
        step();
        chk("rst_src3_vld", 64'(bus.cmp_vld_o), 64'b01);
        chk("rst_src3_rob", 64'(bus.cmp_rob_o[4:0]), 64'd9);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
